// File: rtl/decomp_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decomp_dispatch_ctrl
// Description : Sequences one compressed 256-bit line at a time through the
//               decompressor back end. All-zero, word-same and uncompressed
//               lines are resolved locally; transformer codes are launched on
//               the shared detransformer and awaited with a timeout. Results
//               leave through a registered valid/ready stage.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid_i/in_ready_o, select_i, data_i - input line
//               tf_start_o, tf_sel_o, tf_data_o         - detransformer launch
//               tf_done_i, tf_data_i                    - detransformer result
//               out_valid_o/out_ready_i, data_o, select_o, err_o - result
//               busy_o              - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module decomp_dispatch_ctrl #(
    parameter int NUM_PATTERNS          = 8,
    parameter int NUM_FIRST_TRANSFORMER = 2,
    parameter int NUM_LAST_TRANSFORMER  = 6,
    parameter int LEN_ENCODE            = $clog2(NUM_PATTERNS),
    parameter int TIMEOUT               = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LEN_ENCODE-1:0] select_i,
    input  logic [255:0]          data_i,
    output logic                  tf_start_o,
    output logic [LEN_ENCODE-1:0] tf_sel_o,
    output logic [255:0]          tf_data_o,
    input  logic                  tf_done_i,
    input  logic [255:0]          tf_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [255:0]          data_o,
    output logic [LEN_ENCODE-1:0] select_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [LEN_ENCODE-1:0] c_sel_zero     = '0;
    localparam logic [LEN_ENCODE-1:0] c_sel_wordsame = LEN_ENCODE'(1);
    localparam logic [LEN_ENCODE-1:0] c_sel_uncomp   = LEN_ENCODE'(NUM_PATTERNS - 1);
    localparam logic [LEN_ENCODE-1:0] c_sel_tf_first = LEN_ENCODE'(NUM_FIRST_TRANSFORMER);
    localparam logic [LEN_ENCODE-1:0] c_sel_tf_last  = LEN_ENCODE'(NUM_LAST_TRANSFORMER);
    localparam logic [CNT_W-1:0]      c_cnt_last     = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                r_state, w_nxt_state;
    logic [255:0]          r_data, w_nxt_data;
    logic [LEN_ENCODE-1:0] r_select, w_nxt_select;
    logic                  r_err, w_nxt_err;
    logic                  r_tf_start, w_nxt_tf_start;
    logic [LEN_ENCODE-1:0] r_tf_sel, w_nxt_tf_sel;
    logic [255:0]          r_tf_data, w_nxt_tf_data;
    logic [CNT_W-1:0]      r_cnt, w_nxt_cnt;
    logic                  w_accept;

    // Ready is forced low during reset so nothing is handshaken away.
    always_comb begin
        in_ready_o = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: in_ready_o = 1'b1;
                ST_OUT:  in_ready_o = out_ready_i;
                default: in_ready_o = 1'b0;
            endcase
        end
    end

    assign w_accept = in_valid_i & in_ready_o;

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_data     = r_data;
        w_nxt_select   = r_select;
        w_nxt_err      = r_err;
        w_nxt_tf_start = 1'b0;
        w_nxt_tf_sel   = r_tf_sel;
        w_nxt_tf_data  = r_tf_data;
        w_nxt_cnt      = r_cnt;

        case (r_state)
            ST_WAIT: begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
                // A done arriving on the last allowed cycle still wins.
                if (tf_done_i) begin
                    w_nxt_data  = tf_data_i;
                    w_nxt_err   = 1'b0;
                    w_nxt_state = ST_OUT;
                end else if (r_cnt == c_cnt_last) begin
                    w_nxt_data  = '0;
                    w_nxt_err   = 1'b1;
                    w_nxt_state = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: ;
        endcase

        // An accept (from IDLE, or from OUT while draining) overrides the
        // state-local decisions above so trivial codes stream with no bubble.
        if (w_accept) begin
            w_nxt_select = select_i;
            w_nxt_err    = 1'b0;
            w_nxt_state  = ST_OUT;
            if (select_i == c_sel_zero) begin
                w_nxt_data = '0;
            end else if (select_i == c_sel_wordsame) begin
                w_nxt_data = {8{data_i[255:224]}};
            end else if (select_i == c_sel_uncomp) begin
                w_nxt_data = data_i;
            end else if ((select_i >= c_sel_tf_first) && (select_i <= c_sel_tf_last)) begin
                w_nxt_tf_sel   = select_i;
                w_nxt_tf_data  = data_i;
                w_nxt_tf_start = 1'b1;
                w_nxt_cnt      = '0;
                w_nxt_state    = ST_WAIT;
            end else begin
                w_nxt_data = '0;
                w_nxt_err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_select   <= '0;
            r_err      <= 1'b0;
            r_tf_start <= 1'b0;
            r_tf_sel   <= '0;
            r_tf_data  <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_data     <= w_nxt_data;
            r_select   <= w_nxt_select;
            r_err      <= w_nxt_err;
            r_tf_start <= w_nxt_tf_start;
            r_tf_sel   <= w_nxt_tf_sel;
            r_tf_data  <= w_nxt_tf_data;
            r_cnt      <= w_nxt_cnt;
        end
    end

    assign tf_start_o  = r_tf_start;
    assign tf_sel_o    = r_tf_sel;
    assign tf_data_o   = r_tf_data;
    assign out_valid_o = (r_state == ST_OUT);
    assign data_o      = r_data;
    assign select_o    = r_select;
    assign err_o       = r_err;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_decomp_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decomp_dispatch_ctrl
// Description : Directed self-checking bench for decomp_dispatch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decomp_dispatch_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [2:0]   select_i;
    logic [255:0] data_i;
    logic         tf_start_o;
    logic [2:0]   tf_sel_o;
    logic [255:0] tf_data_o;
    logic         tf_done_i;
    logic [255:0] tf_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [255:0] data_o;
    logic [2:0]   select_o;
    logic         err_o;
    logic         busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    decomp_dispatch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .select_i    (select_i),
        .data_i      (data_i),
        .tf_start_o  (tf_start_o),
        .tf_sel_o    (tf_sel_o),
        .tf_data_o   (tf_data_o),
        .tf_done_i   (tf_done_i),
        .tf_data_i   (tf_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .select_o    (select_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [255:0] D_UNC  = {8{32'h0123_4567}} ^ 256'h1;
    localparam logic [255:0] D_A5   = {32{8'hA5}};
    localparam logic [255:0] D_LATE = {16{16'hBEEF}};
    localparam logic [255:0] D_EDGE = {64{4'h3}};
    localparam logic [255:0] D_TX   = {32{8'h5C}};

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        select_i    = '0;
        data_i      = '0;
        tf_done_i   = 1'b0;
        tf_data_i   = '0;
        out_ready_i = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_in_ready", 256'(in_ready_o), 256'(0));
        chk("rst_out_valid", 256'(out_valid_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_data", data_o, '0);
        chk("rst_tf", {tf_data_o[250:0], tf_sel_o, tf_start_o, err_o}, '0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 256'(in_ready_o), 256'(1));

        // ---------------- word-same ----------------
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        select_i    = 3'd1;
        data_i      = {32'hDEAD_BEEF, 224'h1234};
        tick();
        chk("ws_valid", 256'(out_valid_o), 256'(1));
        chk("ws_data", data_o, {8{32'hDEAD_BEEF}});
        chk("ws_err", 256'(err_o), 256'(0));
        chk("ws_sel", 256'(select_o), 256'(1));

        // ---------------- back-to-back 0, 7, 1 ----------------
        select_i = 3'd0; data_i = D_UNC;
        chk("b2b_rdy0", 256'(in_ready_o), 256'(1));
        tick();
        chk("b2b0_valid", 256'(out_valid_o), 256'(1));
        chk("b2b0_data", data_o, '0);
        select_i = 3'd7; data_i = D_UNC;
        chk("b2b_rdy1", 256'(in_ready_o), 256'(1));
        tick();
        chk("b2b7_valid", 256'(out_valid_o), 256'(1));
        chk("b2b7_data", data_o, D_UNC);
        chk("b2b7_sel", 256'(select_o), 256'(7));
        select_i = 3'd1; data_i = {32'h1234_5678, 224'h0};
        chk("b2b_rdy2", 256'(in_ready_o), 256'(1));
        tick();
        chk("b2b1_valid", 256'(out_valid_o), 256'(1));
        chk("b2b1_data", data_o, {8{32'h1234_5678}});
        in_valid_i = 1'b0;
        tick();
        chk("b2b_idle", 256'(out_valid_o), 256'(0));

        // ---------------- transformer, done after 5 cycles ----------------
        in_valid_i = 1'b1; select_i = 3'd4; data_i = D_TX;
        tick();
        in_valid_i = 1'b0;
        chk("tf_start", 256'(tf_start_o), 256'(1));
        chk("tf_sel", 256'(tf_sel_o), 256'(4));
        chk("tf_data", tf_data_o, D_TX);
        chk("tf_busy", 256'(busy_o), 256'(1));
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("tf_start_once", 256'(tf_start_o), 256'(0));
            chk("tf_wait_rdy", 256'(in_ready_o), 256'(0));
            chk("tf_wait_valid", 256'(out_valid_o), 256'(0));
        end
        tf_done_i = 1'b1; tf_data_i = D_A5;
        tick();
        tf_done_i = 1'b0;
        chk("tf_out_valid", 256'(out_valid_o), 256'(1));
        chk("tf_out_data", data_o, D_A5);
        chk("tf_out_err", 256'(err_o), 256'(0));
        chk("tf_out_sel", 256'(select_o), 256'(4));
        tick();
        chk("tf_idle", 256'(busy_o), 256'(0));

        // ---------------- timeout, late done, held output ----------------
        in_valid_i = 1'b1; select_i = 3'd3; data_i = D_TX;
        out_ready_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i <= 63; i++) tick();
        chk("to_last_wait", 256'(out_valid_o), 256'(0));
        tick();
        chk("to_valid", 256'(out_valid_o), 256'(1));
        chk("to_data", data_o, '0);
        chk("to_err", 256'(err_o), 256'(1));
        chk("to_sel", 256'(select_o), 256'(3));
        tf_done_i = 1'b1; tf_data_i = D_LATE;
        in_valid_i = 1'b1; select_i = 3'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rdy", 256'(in_ready_o), 256'(0));
            chk("hold_data", data_o, '0);
            chk("hold_sel", 256'(select_o), 256'(3));
            chk("hold_err", 256'(err_o), 256'(1));
        end
        tf_done_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        tick();
        chk("hold_idle", 256'(out_valid_o), 256'(0));

        // ---------------- done on the last allowed WAIT cycle ----------------
        in_valid_i = 1'b1; select_i = 3'd5; data_i = D_TX;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i <= 63; i++) tick();
        tf_done_i = 1'b1; tf_data_i = D_EDGE;
        tick();
        tf_done_i = 1'b0;
        chk("edge_valid", 256'(out_valid_o), 256'(1));
        chk("edge_data", data_o, D_EDGE);
        chk("edge_err", 256'(err_o), 256'(0));
        tick();

        // ---------------- reset mid-WAIT ----------------
        in_valid_i = 1'b1; select_i = 3'd6; data_i = D_TX;
        tick();
        in_valid_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("mrst_rdy", 256'(in_ready_o), 256'(0));
        tick();
        chk("mrst_busy", 256'(busy_o), 256'(0));
        chk("mrst_valid", 256'(out_valid_o), 256'(0));
        chk("mrst_tf", {tf_data_o[250:0], tf_sel_o, tf_start_o, err_o}, '0);
        chk("mrst_sel", 256'(select_o), 256'(0));
        rst = 1'b0;
        tf_done_i = 1'b1; tf_data_i = D_LATE;
        tick();
        tf_done_i = 1'b0;
        chk("mrst_late_valid", 256'(out_valid_o), 256'(0));
        chk("mrst_late_data", data_o, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
